// File: rtl/dma_ctrl_if.sv
// -----------------------------------------------------------------------------
// dma_ctrl_if
// Burst command channel between the DMA channel controller and the bus-level
// dma_master. One command is in flight at a time. The master issues
// (src, dst, len) and then waits for a single write-response pulse.
//
//   cmd_valid  : controller -> master, command valid
//   cmd_ready  : master -> controller, command accepted
//   cmd_src    : controller -> master, burst read byte address
//   cmd_dst    : controller -> master, burst write byte address
//   cmd_len    : controller -> master, beats minus one (AXI LEN encoding)
//   burst_done : master -> controller, one-cycle pulse, burst write response seen
//   burst_resp : master -> controller, BRESP of that burst, valid with burst_done
//
// Modports: master = the controller side (drives the command),
//           slave  = the dma_master side (accepts the command, reports done).
// -----------------------------------------------------------------------------
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

interface dma_ctrl_if;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [`AXI_ADDR_BITS-1:0] cmd_src;
    logic [`AXI_ADDR_BITS-1:0] cmd_dst;
    logic [`AXI_LEN_BITS-1:0]  cmd_len;
    logic                      burst_done;
    logic [1:0]                burst_resp;

    modport master (
        output cmd_valid, cmd_src, cmd_dst, cmd_len,
        input  cmd_ready, burst_done, burst_resp
    );

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len,
        output cmd_ready, burst_done, burst_resp
    );
endinterface

// File: rtl/dma_ctrl.sv
// -----------------------------------------------------------------------------
// dma_ctrl
// Single-channel DMA controller. A transfer of len 32-bit words is split into
// bursts of at most MAX_BEATS words. Each burst is issued as one command on
// the dma_ctrl_if channel, and the controller waits for its write response
// before it issues the next one.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous, active-high reset
//   dma_en     : channel enable. Low blocks new transfers and ends the
//                transfer once the in-flight burst completes.
//   start      : one-cycle transfer request, sampled only while idle
//   src_addr   : source byte address (word aligned internally)
//   dst_addr   : destination byte address (word aligned internally)
//   len        : transfer length in 32-bit words
//   irq_clr    : clears done_irq (a completion in the same cycle wins)
//   busy       : transfer in progress (CMD/WAIT/FIN)
//   done_irq   : sticky completion interrupt
//   err        : sticky error for the current/last transfer
//   bus        : burst command channel (master modport)
// -----------------------------------------------------------------------------
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module dma_ctrl #(
    parameter int MAX_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dma_en,
    input  logic                      start,
    input  logic [`AXI_ADDR_BITS-1:0] src_addr,
    input  logic [`AXI_ADDR_BITS-1:0] dst_addr,
    input  logic [31:0]               len,
    input  logic                      irq_clr,
    output logic                      busy,
    output logic                      done_irq,
    output logic                      err,
    dma_ctrl_if.master                bus
);

    localparam int AW = `AXI_ADDR_BITS;
    localparam int LW = `AXI_LEN_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  src_q, src_d;
    logic [AW-1:0]  dst_q, dst_d;
    logic [31:0]    rem_q, rem_d;
    logic [LW-1:0]  len_q, len_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    logic [31:0]    beats_w;
    logic [31:0]    rem_left;

    // Words in the next burst for a given number of remaining words.
    function automatic logic [31:0] burst_beats(input logic [31:0] remaining);
        if (remaining > 32'(MAX_BEATS)) begin
            return 32'(MAX_BEATS);
        end
        return remaining;
    endfunction

    // AXI LEN field for the next burst: beats minus one.
    function automatic logic [LW-1:0] burst_len_field(input logic [31:0] remaining);
        return LW'(burst_beats(remaining) - 32'd1);
    endfunction

    // The burst in flight is fully described by the latched LEN field, so the
    // address/remaining update in WAIT needs no separate beats register.
    assign beats_w  = 32'(len_q) + 32'd1;
    assign rem_left = rem_q - beats_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        len_d   = len_q;
        err_d   = err_q;
        done_d  = done_q;

        if (irq_clr) begin
            done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start && dma_en) begin
                    err_d = 1'b0;
                    if (len != 32'd0) begin
                        src_d   = src_addr & ~AW'(3);
                        dst_d   = dst_addr & ~AW'(3);
                        rem_d   = len;
                        len_d   = burst_len_field(len);
                        state_d = CMD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end

            // dma_en is deliberately not looked at here: an offered command
            // is never withdrawn.
            CMD: begin
                if (bus.cmd_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (bus.burst_done) begin
                    src_d = src_q + AW'(beats_w << 2);
                    dst_d = dst_q + AW'(beats_w << 2);
                    rem_d = rem_left;
                    if (bus.burst_resp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (rem_left == 32'd0 || !dma_en) begin
                        state_d = FIN;
                    end else begin
                        len_d   = burst_len_field(rem_left);
                        state_d = CMD;
                    end
                end
            end

            // Completion overrides a simultaneous irq_clr.
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign done_irq      = done_q;
    assign err           = err_q;
    assign bus.cmd_valid = (state_q == CMD);
    assign bus.cmd_src   = src_q;
    assign bus.cmd_dst   = dst_q;
    assign bus.cmd_len   = len_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dma_ctrl
// Self-checking bench for dma_ctrl. The bench plays the dma_master role on
// the command channel. Each transfer's expected burst list is built up front
// from plain arithmetic: split len into min(rem, MAX_BEATS) chunks and advance
// the addresses by 4 bytes per word. The bench then checks the DUT against that
// list cycle by cycle, with random ready stalls, response delays, error
// responses, enable drops and start pulses while busy.
// -----------------------------------------------------------------------------
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module tb_dma_ctrl;

    localparam int MAXB = 16;
    localparam int AW   = `AXI_ADDR_BITS;
    localparam int LW   = `AXI_LEN_BITS;

    typedef struct packed {
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        logic [LW-1:0] l;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          dma_en;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [31:0]   len;
    logic          irq_clr;
    logic          busy;
    logic          done_irq;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    dma_ctrl_if bus ();

    dma_ctrl #(.MAX_BEATS(MAXB)) dut (
        .clk      (clk),
        .rst      (rst),
        .dma_en   (dma_en),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .irq_clr  (irq_clr),
        .busy     (busy),
        .done_irq (done_irq),
        .err      (err),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string p);
        check_eq({p, "_busy"},  32'(busy), 0);
        check_eq({p, "_done"},  32'(done_irq), 0);
        check_eq({p, "_err"},   32'(err), 0);
        check_eq({p, "_valid"}, 32'(bus.cmd_valid), 0);
        check_eq({p, "_src"},   32'(bus.cmd_src), 0);
        check_eq({p, "_dst"},   32'(bus.cmd_dst), 0);
        check_eq({p, "_len"},   32'(bus.cmd_len), 0);
    endtask

    function automatic logic [1:0] rand_resp();
        if ($urandom_range(0, 3) == 0) begin
            return 2'($urandom_range(1, 3));
        end
        return 2'b00;
    endfunction

    // One complete transfer with the bench acting as dma_master.
    //   drop_idx    : burst index during whose WAIT dma_en is lowered (-1 = never)
    //   stall_first : cycles cmd_ready is held low on the first command offer,
    //                 with stray burst_done/SLVERR pulses that must be ignored
    //   fixed_dly   : cycles from acceptance to burst_done (0 = random 1..5)
    //   resp0       : response for the first burst
    //   rnd         : random ready/responses and start pulses while busy
    //   clr_in_fin  : pulse irq_clr in the FIN cycle
    task automatic run_xfer(input logic [31:0] l, input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input int drop_idx, input int stall_first, input int fixed_dly,
                            input logic [1:0] resp0, input bit rnd, input bit clr_in_fin);
        cmd_t          exp_q[$];
        cmd_t          c;
        logic [31:0]   rem;
        logic [AW-1:0] a, b;
        logic [31:0]   beats;
        logic [1:0]    r;
        int            n_exp, n_acc, n_done, dly, stall, fin_cnt, cyc;
        bit            pending, waiting, exp_err;

        // Reference: burst list straight from the length/address rules.
        rem = l;
        a   = s & ~AW'(3);
        b   = d & ~AW'(3);
        while (rem != 0) begin
            beats = (rem > MAXB) ? MAXB : rem;
            c.s = a;
            c.d = b;
            c.l = LW'(beats - 1);
            exp_q.push_back(c);
            a   = a + AW'(4 * beats);
            b   = b + AW'(4 * beats);
            rem = rem - beats;
        end
        n_exp = (drop_idx >= 0 && drop_idx < exp_q.size()) ? drop_idx + 1 : exp_q.size();

        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check_eq("pre_busy", 32'(busy), 0);
        check_eq("irq_clr", 32'(done_irq), 0);
        dma_en   = 1'b1;
        start    = 1'b1;
        len      = l;
        src_addr = s;
        dst_addr = d;
        @(negedge clk);
        start    = 1'b0;
        len      = $urandom;
        src_addr = $urandom;
        dst_addr = $urandom;
        check_eq("busy_start", 32'(busy), 1);
        check_eq("err_clr_start", 32'(err), 0);

        pending = (l != 0);
        waiting = 1'b0;
        exp_err = 1'b0;
        stall   = stall_first;
        n_acc   = 0;
        n_done  = 0;
        dly     = 0;
        cyc     = 0;
        fin_cnt = (l == 0) ? 0 : -1;

        forever begin
            if (fin_cnt >= 0) fin_cnt++;
            cyc++;
            if (cyc > 3000) begin
                check_eq("timeout", 0, 1);
                break;
            end

            check_eq("cmd_valid", 32'(bus.cmd_valid), 32'(pending));
            if (pending && bus.cmd_valid && n_acc < exp_q.size()) begin
                check_eq("cmd_src", 32'(bus.cmd_src), 32'(exp_q[n_acc].s));
                check_eq("cmd_dst", 32'(bus.cmd_dst), 32'(exp_q[n_acc].d));
                check_eq("cmd_len", 32'(bus.cmd_len), 32'(exp_q[n_acc].l));
            end
            if (fin_cnt == 1) begin
                check_eq("fin_busy", 32'(busy), 1);
                check_eq("fin_irq_early", 32'(done_irq), 0);
            end
            if (fin_cnt == 2) begin
                check_eq("done_irq", 32'(done_irq), 1);
                check_eq("done_busy", 32'(busy), 0);
                check_eq("done_err", 32'(err), 32'(exp_err));
                check_eq("burst_count", n_acc, n_exp);
                break;
            end

            bus.cmd_ready  = 1'b0;
            bus.burst_done = 1'b0;
            bus.burst_resp = 2'b00;
            irq_clr        = 1'b0;
            start          = rnd && ($urandom_range(0, 5) == 0);
            len            = $urandom_range(1, 40);

            if (pending) begin
                if (stall > 0) begin
                    stall--;
                    if ($urandom_range(0, 1) == 1) begin
                        bus.burst_done = 1'b1;
                        bus.burst_resp = 2'b10;
                    end
                end else begin
                    bus.cmd_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (bus.cmd_ready) begin
                        pending = 1'b0;
                        waiting = 1'b1;
                        n_acc++;
                        dly = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 5);
                    end
                end
            end else if (waiting) begin
                if (n_done == drop_idx) dma_en = 1'b0;
                dly--;
                if (dly == 0) begin
                    r = (n_done == 0) ? resp0 : (rnd ? rand_resp() : 2'b00);
                    bus.burst_done = 1'b1;
                    bus.burst_resp = r;
                    if (r != 2'b00) exp_err = 1'b1;
                    n_done++;
                    waiting = 1'b0;
                    if (n_done < n_exp) pending = 1'b1;
                    else fin_cnt = 0;
                end
            end else if (fin_cnt == 1 && clr_in_fin) begin
                irq_clr = 1'b1;
            end

            @(negedge clk);
        end

        start          = 1'b0;
        irq_clr        = 1'b0;
        dma_en         = 1'b1;
        bus.cmd_ready  = 1'b0;
        bus.burst_done = 1'b0;
        bus.burst_resp = 2'b00;
    endtask

    initial begin
        int wait_cyc;

        rst            = 1'b1;
        dma_en         = 1'b0;
        start          = 1'b0;
        src_addr       = '0;
        dst_addr       = '0;
        len            = '0;
        irq_clr        = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.burst_done = 1'b0;
        bus.burst_resp = 2'b00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Three bursts 16/16/8, ready always high, response 3 cycles after accept.
        run_xfer(32'd40, 32'h1000, 32'h2000, -1, 0, 3, 2'b00, 1'b0, 1'b0);

        // Zero length: straight to FIN, no command.
        run_xfer(32'd0, 32'h1234, 32'h5678, -1, 0, 0, 2'b00, 1'b0, 1'b0);

        // Five-cycle ready stall on the first offer.
        run_xfer(32'd24, 32'h0000_0100, 32'h0000_0800, -1, 5, 2, 2'b00, 1'b0, 1'b0);

        // Enable dropped during the second burst of three.
        run_xfer(32'd48, 32'h4000, 32'h8000, 1, 0, 3, 2'b00, 1'b0, 1'b0);

        // SLVERR on the first burst; the next transfer's start clears err.
        run_xfer(32'd20, 32'h0000_0A00, 32'h0000_0B00, -1, 0, 2, 2'b10, 1'b0, 1'b0);
        run_xfer(32'd16, 32'h0000_0C00, 32'h0000_0D00, -1, 0, 1, 2'b00, 1'b0, 1'b0);

        // Unaligned addresses that wrap past the top of the address space.
        run_xfer(32'd20, 32'hFFFF_FFC2, 32'hFFFF_FFF1, -1, 0, 0, 2'b00, 1'b1, 1'b0);

        // start with the channel disabled is ignored.
        @(negedge clk);
        dma_en  = 1'b0;
        start   = 1'b1;
        len     = 32'd8;
        irq_clr = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        irq_clr = 1'b0;
        check_eq("dis_busy", 32'(busy), 0);
        check_eq("dis_valid", 32'(bus.cmd_valid), 0);
        @(negedge clk);
        check_eq("dis_busy2", 32'(busy), 0);
        check_eq("dis_done", 32'(done_irq), 0);

        // Reset while a burst is outstanding, then its late burst_done.
        dma_en   = 1'b1;
        start    = 1'b1;
        len      = 32'd40;
        src_addr = 32'h300;
        dst_addr = 32'h400;
        @(negedge clk);
        start         = 1'b0;
        bus.cmd_ready = 1'b1;
        wait_cyc      = 0;
        while (!bus.cmd_valid && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_eq("rw_valid", 32'(bus.cmd_valid), 1);
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        check_eq("rw_wait_busy", 32'(busy), 1);
        check_eq("rw_wait_valid", 32'(bus.cmd_valid), 0);
        rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        bus.burst_done = 1'b1;
        bus.burst_resp = 2'b10;
        check_all_zero("rw_rst");
        @(negedge clk);
        bus.burst_done = 1'b0;
        bus.burst_resp = 2'b00;
        check_all_zero("rw_late_done");
        @(negedge clk);
        check_all_zero("rw_idle");

        // Short transfer after the reset, with irq_clr in the FIN cycle.
        run_xfer(32'd4, 32'h0000_5003, 32'h0000_6001, -1, 0, 2, 2'b00, 1'b0, 1'b1);

        // Randomized transfers.
        for (int i = 0; i < 25; i++) begin
            logic [31:0] rl;
            int          rd, rs;
            rl = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(1, 70));
            rd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
            rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_xfer(rl, AW'($urandom), AW'($urandom), rd, rs, 0, rand_resp(), 1'b1,
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
